btn_debounce_sp: RTL and testbench



---
 rtl/btn_debounce_sp.sv | 203 ++++++++++++++++++++
 tb/tb_btn_debounce_sp.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_sp.sv
// btn_debounce_sp: push-button debouncer and enable-pulse generator.
//
// A raw, bouncing, asynchronous button is synchronised and then qualified by
// a window counter of 2^N_DC clocks, giving four glitch-free registered
// outputs:
//   Clk   in  system clock
//   Reset in  asynchronous, active-high reset
//   PB    in  raw push-button, active-high, asynchronous to Clk
//   DPB   out debounced button level
//   SCEN  out one-cycle pulse per debounced press
//   MCEN  out press pulse plus auto-repeat pulses while the button is held
//   CCEN  out high every cycle while the press is confirmed and held
//
// Optional feature macro: BTN_MCEN_REPEAT_EN
//   defined   - hold counter and auto-repeat MCEN pulses are present
//   undefined - no hold counter; MCEN is identical to SCEN
`timescale 1ns/1ps

module btn_debounce_sp #(
  parameter int unsigned N_DC         = 20,
  parameter int unsigned HOLD_WINDOWS = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic PB,
  output logic DPB,
  output logic SCEN,
  output logic MCEN,
  output logic CCEN
);

  localparam int unsigned     HCNT_W   = 8;
  localparam logic [N_DC-1:0] CNT_TERM = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WQ   = 3'd1,
    S_SCEN = 3'd2,
    S_HELD = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_pb_m;
  logic            r_pb_s;
  logic [N_DC-1:0] r_cnt;
  logic [N_DC-1:0] w_cnt_nxt;
  logic            w_term;
  logic            w_dpb_nxt;
  logic            w_scen_nxt;
  logic            w_ccen_nxt;
  logic            r_dpb;
  logic            r_scen;
  logic            r_ccen;

  // Two-flop synchroniser; nothing else looks at PB.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pb_m <= 1'b0;
      r_pb_s <= 1'b0;
    end else begin
      r_pb_m <= PB;
      r_pb_s <= r_pb_m;
    end
  end

  assign w_term = (r_cnt == CNT_TERM);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next-cycle output levels; the synchronised level always
  // beats a simultaneous terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_dpb_nxt   = 1'b0;
    w_scen_nxt  = 1'b0;
    w_ccen_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pb_s) w_state_nxt = S_WQ;
      end
      S_WQ: begin
        if (!r_pb_s)     w_state_nxt = S_IDLE;
        else if (w_term) w_state_nxt = S_SCEN;
      end
      S_SCEN: begin
        w_state_nxt = S_HELD;
      end
      S_HELD: begin
        if (!r_pb_s) w_state_nxt = S_WR;
      end
      S_WR: begin
        if (r_pb_s)      w_state_nxt = S_HELD;
        else if (w_term) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_SCEN: begin
        w_dpb_nxt  = 1'b1;
        w_scen_nxt = 1'b1;
        w_ccen_nxt = 1'b1;
      end
      S_HELD: begin
        w_dpb_nxt  = 1'b1;
        w_ccen_nxt = 1'b1;
      end
      S_WR: begin
        w_dpb_nxt  = 1'b1;
      end
      default: begin
        w_dpb_nxt  = 1'b0;
      end
    endcase
  end

  // Window counter: restarts on every state change, free-runs (and wraps)
  // in the qualifying states.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if ((r_state == S_WQ) || (r_state == S_HELD) || (r_state == S_WR)) begin
      w_cnt_nxt = r_cnt + N_DC'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Registered outputs, aligned with the state they decode.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dpb  <= 1'b0;
      r_scen <= 1'b0;
      r_ccen <= 1'b0;
    end else begin
      r_dpb  <= w_dpb_nxt;
      r_scen <= w_scen_nxt;
      r_ccen <= w_ccen_nxt;
    end
  end

  assign DPB  = r_dpb;
  assign SCEN = r_scen;
  assign CCEN = r_ccen;

`ifdef BTN_MCEN_REPEAT_EN
  localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(HOLD_WINDOWS);

  logic [HCNT_W-1:0] r_hcnt;
  logic              w_held_term;
  logic              w_rpt;
  logic              r_mcen;

  // A full window completed while still held.
  assign w_held_term = (r_state == S_HELD) && r_pb_s && w_term;
  // Repeat only once the hold counter has already saturated.
  assign w_rpt       = w_held_term && (r_hcnt == HOLD_MAX);

  // Hold counter: counts completed held windows, saturating; survives
  // release bounces, restarts on each new press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hcnt <= '0;
    end else if (r_state == S_SCEN) begin
      r_hcnt <= '0;
    end else if (w_held_term && (r_hcnt != HOLD_MAX)) begin
      r_hcnt <= r_hcnt + HCNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mcen <= 1'b0;
    end else begin
      r_mcen <= w_scen_nxt | w_rpt;
    end
  end

  assign MCEN = r_mcen;
`else
  localparam int unsigned HOLD_UNUSED = HOLD_WINDOWS + HCNT_W;
  assign MCEN = r_scen;
`endif

endmodule

// File: tb/tb_btn_debounce_sp.sv
`timescale 1ns/1ps

module tb_btn_debounce_sp;

  localparam int unsigned N_DC    = 4;
  localparam int unsigned HOLD    = 2;
  localparam int          WIN     = 16;       // 2^N_DC
  localparam int          CONFIRM = WIN + 1;  // consecutive synced samples to flip the level
  localparam int          PRESS_LAT = WIN + 3;
`ifdef BTN_MCEN_REPEAT_EN
  localparam int EXP_HOLD_MCEN = 5;  // press pulse + repeats at edges 68, 84, 100, 116
`else
  localparam int EXP_HOLD_MCEN = 1;
`endif

  logic Clk = 1'b0;
  logic Reset;
  logic PB;
  logic DPB, SCEN, MCEN, CCEN;

  int vectors = 0;
  int errors  = 0;

  always #5 Clk = ~Clk;

  btn_debounce_sp #(.N_DC(N_DC), .HOLD_WINDOWS(HOLD)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .PB   (PB),
    .DPB  (DPB),
    .SCEN (SCEN),
    .MCEN (MCEN),
    .CCEN (CCEN)
  );

  // Reference model: run-length view of the synchronised button.
  logic m_s1, m_s2;
  bit   m_pressed, m_skip;
  int   m_p, m_o, m_z, m_h;
  logic m_dpb, m_scen, m_mcen, m_ccen;

  function automatic void model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0;
    m_pressed = 1'b0; m_skip = 1'b0;
    m_p = 0; m_o = 0; m_z = 0; m_h = 0;
    m_dpb = 1'b0; m_scen = 1'b0; m_mcen = 1'b0; m_ccen = 1'b0;
  endfunction

  // Advance the model by one clock edge.
  function automatic void model_edge();
    m_scen = 1'b0;
    m_mcen = 1'b0;
    if (Reset) begin
      model_reset();
      return;
    end
    if (!m_pressed) begin
      if (m_s2) begin
        m_p++;
        if (m_p == CONFIRM) begin
          m_pressed = 1'b1; m_skip = 1'b1;
          m_p = 0; m_o = 0; m_z = 0; m_h = 0;
          m_scen = 1'b1; m_mcen = 1'b1;
        end
      end else begin
        m_p = 0;
      end
    end else if (m_skip) begin
      m_skip = 1'b0;  // the press-pulse cycle ignores the button
    end else if (m_s2) begin
      if (m_z > 0) begin
        m_z = 0; m_o = 0;  // release bounce: back to held, new window
      end else begin
`ifdef BTN_MCEN_REPEAT_EN
        if ((m_o % WIN) == WIN - 1) begin
          if (m_h == HOLD) m_mcen = 1'b1;
          if (m_h < HOLD) m_h++;
        end
`endif
        m_o++;
      end
    end else begin
      m_o = 0;
      m_z++;
      if (m_z == CONFIRM) begin
        m_pressed = 1'b0; m_z = 0; m_p = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = PB;
    m_dpb  = m_pressed;
    m_ccen = m_pressed && (m_z == 0);
  endfunction

  // Apply one PB value for one clock, step the model, settle past the edge.
  task automatic step(input logic pb);
    PB = pb;
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    PB    = 1'b0;
    #1 Reset = 1'b1;
    model_reset();
    #1;
    if ({DPB, SCEN, MCEN, CCEN} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async outs(dpb,scen,mcen,ccen)=%b expected 0000", {DPB, SCEN, MCEN, CCEN});
    end
    vectors++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      if ({DPB, SCEN, MCEN, CCEN} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d outs=%b expected 0000", i, {DPB, SCEN, MCEN, CCEN});
      end
      vectors++;
    end
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      if ({DPB, SCEN, MCEN, CCEN} !== {m_dpb, m_scen, m_mcen, m_ccen}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d outs=%b expected %b", i, {DPB, SCEN, MCEN, CCEN}, {m_dpb, m_scen, m_mcen, m_ccen});
      end
      vectors++;
    end
  endtask

  task automatic test_clean_press();
    int first_scen = -1;
    int first_dpb  = -1;
    int n_scen = 0;
    for (int i = 1; i <= 140; i++) begin
      step(i <= 100);
      if (SCEN) n_scen++;
      if (SCEN && first_scen < 0) first_scen = i;
      if (DPB && first_dpb < 0) first_dpb = i;
      if ({DPB, SCEN, MCEN, CCEN} !== {m_dpb, m_scen, m_mcen, m_ccen}) begin
        errors++;
        $display("FAIL clean_press edge=%0d outs=%b expected %b", i, {DPB, SCEN, MCEN, CCEN}, {m_dpb, m_scen, m_mcen, m_ccen});
      end
      vectors++;
    end
    if (first_scen !== PRESS_LAT) begin
      errors++;
      $display("FAIL clean_press_latency scen_edge=%0d expected %0d", first_scen, PRESS_LAT);
    end
    vectors++;
    if (first_dpb !== PRESS_LAT) begin
      errors++;
      $display("FAIL clean_press_dpb dpb_edge=%0d expected %0d", first_dpb, PRESS_LAT);
    end
    vectors++;
    if (n_scen !== 1) begin
      errors++;
      $display("FAIL clean_press_count scen=%0d expected 1", n_scen);
    end
    vectors++;
  endtask

  task automatic test_bounce_press();
    int n_dpb = 0;
    for (int i = 0; i < 90; i++) begin
      step((i < 60) ? logic'((i / 5) % 2 == 0) : 1'b0);
      if (DPB || SCEN) n_dpb++;
      if ({DPB, SCEN, MCEN, CCEN} !== {m_dpb, m_scen, m_mcen, m_ccen}) begin
        errors++;
        $display("FAIL bounce_press cyc=%0d outs=%b expected %b", i, {DPB, SCEN, MCEN, CCEN}, {m_dpb, m_scen, m_mcen, m_ccen});
      end
      vectors++;
    end
    if (n_dpb !== 0) begin
      errors++;
      $display("FAIL bounce_press_quiet active_cycles=%0d expected 0", n_dpb);
    end
    vectors++;
  endtask

  task automatic test_hold_repeat();
    int n_scen = 0;
    int n_mcen = 0;
    for (int i = 1; i <= 160; i++) begin
      step(i <= 120);
      if (SCEN) n_scen++;
      if (MCEN) n_mcen++;
      if ({DPB, SCEN, MCEN, CCEN} !== {m_dpb, m_scen, m_mcen, m_ccen}) begin
        errors++;
        $display("FAIL hold_repeat edge=%0d outs=%b expected %b", i, {DPB, SCEN, MCEN, CCEN}, {m_dpb, m_scen, m_mcen, m_ccen});
      end
      vectors++;
    end
    if (n_scen !== 1) begin
      errors++;
      $display("FAIL hold_repeat_scen count=%0d expected 1", n_scen);
    end
    vectors++;
    if (n_mcen !== EXP_HOLD_MCEN) begin
      errors++;
      $display("FAIL hold_repeat_mcen count=%0d expected %0d", n_mcen, EXP_HOLD_MCEN);
    end
    vectors++;
  endtask

  task automatic test_release_bounce();
    logic pat [$];
    int n_scen = 0;
    for (int i = 0; i < 40; i++) pat.push_back(1'b1);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) pat.push_back(1'b0);
      for (int i = 0; i < 4; i++) pat.push_back(1'b1);
    end
    for (int i = 0; i < 40; i++) pat.push_back(1'b0);
    foreach (pat[i]) begin
      step(pat[i]);
      if (SCEN) n_scen++;
      if ({DPB, SCEN, MCEN, CCEN} !== {m_dpb, m_scen, m_mcen, m_ccen}) begin
        errors++;
        $display("FAIL release_bounce cyc=%0d outs=%b expected %b", i, {DPB, SCEN, MCEN, CCEN}, {m_dpb, m_scen, m_mcen, m_ccen});
      end
      vectors++;
    end
    if (n_scen !== 1) begin
      errors++;
      $display("FAIL release_bounce_scen count=%0d expected 1", n_scen);
    end
    vectors++;
    if (DPB !== 1'b0) begin
      errors++;
      $display("FAIL release_bounce_final dpb=%b expected 0", DPB);
    end
    vectors++;
  endtask

  task automatic test_reset_mid_held();
    int first_scen = -1;
    for (int i = 0; i < 30; i++) step(1'b1);
    if (CCEN !== 1'b1) begin
      errors++;
      $display("FAIL mid_held_precondition ccen=%b expected 1", CCEN);
    end
    vectors++;
    #3 Reset = 1'b1;
    model_reset();
    #1;
    if ({DPB, SCEN, MCEN, CCEN} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_held_async outs=%b expected 0000", {DPB, SCEN, MCEN, CCEN});
    end
    vectors++;
    @(posedge Clk); #1;
    step(1'b1);
    step(1'b1);
    Reset = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      step(1'b1);
      if (SCEN && first_scen < 0) first_scen = i;
      if ({DPB, SCEN, MCEN, CCEN} !== {m_dpb, m_scen, m_mcen, m_ccen}) begin
        errors++;
        $display("FAIL mid_held_repress edge=%0d outs=%b expected %b", i, {DPB, SCEN, MCEN, CCEN}, {m_dpb, m_scen, m_mcen, m_ccen});
      end
      vectors++;
    end
    if (first_scen !== PRESS_LAT) begin
      errors++;
      $display("FAIL mid_held_latency scen_edge=%0d expected %0d", first_scen, PRESS_LAT);
    end
    vectors++;
    for (int i = 0; i < 40; i++) step(1'b0);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 30; i++) begin
      step(i == 0);
      if ({DPB, SCEN, MCEN, CCEN} !== 4'b0000) begin
        errors++;
        $display("FAIL glitch cyc=%0d outs=%b expected 0000", i, {DPB, SCEN, MCEN, CCEN});
      end
      vectors++;
    end
  endtask

  task automatic test_random();
    int n_scen = 0;
    int m_n_scen = 0;
    logic lvl = 1'b0;
    int cyc = 0;
    while (cyc < 2000) begin
      int len = (($urandom % 4) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 12));
      lvl = ~lvl;
      for (int k = 0; k < len; k++) begin
        step(lvl);
        if (SCEN) n_scen++;
        if (m_scen) m_n_scen++;
        if ({DPB, SCEN, MCEN, CCEN} !== {m_dpb, m_scen, m_mcen, m_ccen}) begin
          errors++;
          $display("FAIL random cyc=%0d outs=%b expected %b", cyc, {DPB, SCEN, MCEN, CCEN}, {m_dpb, m_scen, m_mcen, m_ccen});
        end
        vectors++;
        cyc++;
      end
    end
    for (int i = 0; i < 40; i++) step(1'b0);
    if (n_scen !== m_n_scen) begin
      errors++;
      $display("FAIL random_scen_count count=%0d expected %0d", n_scen, m_n_scen);
    end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_hold_repeat();
    test_release_bounce();
    test_reset_mid_held();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
